// File: rtl/dist_seq_pkg.sv
// rtl/dist_seq_pkg.sv - shared states and float32 constants for the distance-unit sequencer
package dist_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dist_pair_issuer_fp_mag_lt.sv
// rtl/dist_pair_issuer_fp_mag_lt.sv - float32 magnitude less-than with NaN/Inf flag on operand a
module fp_mag_lt
  import dist_seq_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        lt,
  output logic        nan_or_inf
);

  // For non-special floats the sign-stripped bit pattern orders like the magnitude.
  assign nan_or_inf = (a[30:23] == FP_EXP_MAX);
  assign lt         = (a[30:0] < b[30:0]);

endmodule

// File: rtl/dist_pair_issuer.sv
// rtl/dist_pair_issuer.sv - sequences tagged point pairs through the distance unit and flags collisions
module dist_pair_issuer
  import dist_seq_pkg::*;
#(
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 255,
  parameter int TAG_W      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [31:0]      in_a1,
  input  logic [31:0]      in_a2,
  input  logic [31:0]      in_a3,
  input  logic [31:0]      in_b1,
  input  logic [31:0]      in_b2,
  input  logic [31:0]      in_b3,
  input  logic [31:0]      in_thr,
  output logic [31:0]      dc_a1,
  output logic [31:0]      dc_a2,
  output logic [31:0]      dc_a3,
  output logic [31:0]      dc_b1,
  output logic [31:0]      dc_b2,
  output logic [31:0]      dc_b3,
  output logic             dc_rst_n,
  input  logic [31:0]      dc_res,
  input  logic             dc_rdy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      out_dist,
  output logic             out_collide,
  output logic             out_timeout,
  output logic             busy
);

  localparam int CNT_W = $clog2(max_int(CLR_CYCLES, TIMEOUT) + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [2:0][31:0]    a_q, a_d, b_q, b_d;
  logic [31:0]         thr_q, thr_d;
  logic [31:0]         dist_q, dist_d;
  logic                collide_q, collide_d;
  logic                timeout_q, timeout_d;
  logic                res_lt, res_special;

  fp_mag_lt u_mag_lt (
    .a          (dc_res),
    .b          (thr_q),
    .lt         (res_lt),
    .nan_or_inf (res_special)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tag_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      thr_q     <= '0;
      dist_q    <= '0;
      collide_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tag_q     <= tag_d;
      a_q       <= a_d;
      b_q       <= b_d;
      thr_q     <= thr_d;
      dist_q    <= dist_d;
      collide_q <= collide_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tag_d     = tag_q;
    a_d       = a_q;
    b_d       = b_q;
    thr_d     = thr_q;
    dist_d    = dist_q;
    collide_d = collide_q;
    timeout_d = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          tag_d   = in_tag;
          a_d     = {in_a3, in_a2, in_a1};
          b_d     = {in_b3, in_b2, in_b1};
          thr_d   = in_thr;
        end
      end
      ST_CLEAR: begin
        // dc_rdy is deliberately not looked at here: it may be left over from the last pair.
        if (cnt_q == CNT_W'(CLR_CYCLES - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (dc_rdy) begin
          state_d   = ST_HOLD;
          dist_d    = dc_res;
          collide_d = res_lt & ~res_special;
          timeout_d = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = ST_HOLD;
          dist_d    = FP_QNAN;
          collide_d = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    dc_rst_n  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_CLEAR: ;
      ST_RUN:   dc_rst_n = 1'b1;
      ST_HOLD: begin
        dc_rst_n  = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign dc_a1       = a_q[0];
  assign dc_a2       = a_q[1];
  assign dc_a3       = a_q[2];
  assign dc_b1       = b_q[0];
  assign dc_b2       = b_q[1];
  assign dc_b3       = b_q[2];
  assign out_tag     = tag_q;
  assign out_dist    = dist_q;
  assign out_collide = collide_q;
  assign out_timeout = timeout_q;

endmodule

// File: tb/tb_dist_pair_issuer.sv
// tb/tb_dist_pair_issuer.sv - bench for dist_pair_issuer with a stub distance unit and float reference model
module tb_dist_pair_issuer;

  localparam int CLR = 2;
  localparam int TMO = 20;
  localparam int TW  = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] in_tag = '0;
  logic [31:0]   in_a1 = '0, in_a2 = '0, in_a3 = '0, in_b1 = '0, in_b2 = '0, in_b3 = '0, in_thr = '0;
  logic [31:0]   dc_a1, dc_a2, dc_a3, dc_b1, dc_b2, dc_b3;
  logic          dc_rst_n;
  logic [31:0]   dc_res;
  logic          dc_rdy;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [TW-1:0] out_tag;
  logic [31:0]   out_dist;
  logic          out_collide, out_timeout, busy;

  dist_pair_issuer #(.CLR_CYCLES(CLR), .TIMEOUT(TMO), .TAG_W(TW)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .in_a1(in_a1), .in_a2(in_a2), .in_a3(in_a3), .in_b1(in_b1), .in_b2(in_b2), .in_b3(in_b3),
    .in_thr(in_thr), .dc_a1(dc_a1), .dc_a2(dc_a2), .dc_a3(dc_a3), .dc_b1(dc_b1), .dc_b2(dc_b2),
    .dc_b3(dc_b3), .dc_rst_n(dc_rst_n), .dc_res(dc_res), .dc_rdy(dc_rdy), .out_valid(out_valid),
    .out_ready(out_ready), .out_tag(out_tag), .out_dist(out_dist), .out_collide(out_collide),
    .out_timeout(out_timeout), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Stub distance unit: result appears after lat cycles out of clear, or never.
  int          lat = 10;
  bit          never = 1'b0;
  bit          force_rdy = 1'b0;
  logic [31:0] res_val = '0;
  int          dc_cnt = 0;
  always @(posedge CLK) begin
    if (!dc_rst_n) dc_cnt <= 0;
    else           dc_cnt <= dc_cnt + 1;
  end
  always_comb begin
    dc_res = res_val;
    dc_rdy = force_rdy | (dc_rst_n & ~never & (dc_cnt >= lat));
  end

  logic [TW-1:0] m_tag;
  logic [31:0]   m_c [6];
  logic [31:0]   o_c [6];
  logic [31:0]   m_thr;
  int            t_acc;
  logic [TW-1:0] e_tag;
  logic [31:0]   e_dist;
  logic          e_col, e_to;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  function automatic real f2r_mag(input logic [31:0] f);
    int  e;
    real m;
    e = int'(f[30:23]);
    m = real'(f[22:0]) / 8388608.0;
    if (e == 0) return m * (2.0 ** (-126));
    return (1.0 + m) * (2.0 ** (e - 127));
  endfunction

  function automatic logic model_collide(input logic [31:0] res, input logic [31:0] thr);
    if (res[30:23] == 8'hFF) return 1'b0;
    return f2r_mag(res) < f2r_mag(thr);
  endfunction

  task automatic drive_pair();
    in_tag = m_tag;
    in_a1 = m_c[0]; in_a2 = m_c[1]; in_a3 = m_c[2];
    in_b1 = m_c[3]; in_b2 = m_c[4]; in_b3 = m_c[5];
    in_thr = m_thr;
    in_valid = 1'b1;
  endtask

  task automatic start_pair();
    int g;
    drive_pair();
    g = 0;
    while (in_ready !== 1'b1 && g < 200) begin
      @(negedge CLK);
      g++;
    end
    chk("accept_wait", 32'(g < 200), 32'd1);
    t_acc = cyc + 1;
    o_c = m_c;
    @(negedge CLK);
    in_valid = 1'b0;
    in_a1 = $urandom; in_b3 = $urandom; in_thr = $urandom; in_tag = TW'($urandom);
    chk("in_ready_after_accept", 32'(in_ready), 32'd0);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("dc_a1", dc_a1, o_c[0]); chk("dc_a2", dc_a2, o_c[1]); chk("dc_a3", dc_a3, o_c[2]);
    chk("dc_b1", dc_b1, o_c[3]); chk("dc_b2", dc_b2, o_c[4]); chk("dc_b3", dc_b3, o_c[5]);
  endtask

  task automatic check_clear(input bit stale);
    int low;
    low = 0;
    while (dc_rst_n === 1'b0 && low < 50) begin
      force_rdy = stale;
      low++;
      @(negedge CLK);
    end
    force_rdy = 1'b0;
    chk("clear_len", 32'(low), 32'(CLR));
  endtask

  task automatic wait_result();
    int g, k;
    e_to   = never || (lat + 1 > TMO);
    k      = e_to ? TMO : lat + 1;
    e_tag  = m_tag;
    e_dist = e_to ? 32'h7FC0_0000 : res_val;
    e_col  = e_to ? 1'b0 : model_collide(res_val, m_thr);
    g = 0;
    while (out_valid !== 1'b1 && g < 300) begin
      @(negedge CLK);
      g++;
    end
    chk("result_time", 32'(cyc), 32'(t_acc + CLR + k));
    chk("out_tag", 32'(out_tag), 32'(e_tag));
    chk("out_dist", out_dist, e_dist);
    chk("out_collide", 32'(out_collide), 32'(e_col));
    chk("out_timeout", 32'(out_timeout), 32'(e_to));
  endtask

  task automatic hold_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_dc_rst_n", 32'(dc_rst_n), 32'd1);
      chk("hold_tag", 32'(out_tag), 32'(e_tag));
      chk("hold_dist", out_dist, e_dist);
      chk("hold_collide", 32'(out_collide), 32'(e_col));
      chk("hold_timeout", 32'(out_timeout), 32'(e_to));
      chk("hold_dc_a1", dc_a1, o_c[0]);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string where);
    chk({where, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({where, "_dc_rst_n"}, 32'(dc_rst_n), 32'd0);
    chk({where, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({where, "_out_dist"}, out_dist, 32'd0);
    chk({where, "_out_tag"}, 32'(out_tag), 32'd0);
    chk({where, "_out_collide"}, 32'(out_collide), 32'd0);
    chk({where, "_out_timeout"}, 32'(out_timeout), 32'd0);
    chk({where, "_busy"}, 32'(busy), 32'd0);
    chk({where, "_dc_a1"}, dc_a1, 32'd0);
    chk({where, "_dc_b3"}, dc_b3, 32'd0);
  endtask

  task automatic set_basic_pair(input logic [TW-1:0] tag, input logic [31:0] thr);
    m_tag = tag;
    m_c[0] = 32'h0; m_c[1] = 32'h0; m_c[2] = 32'h0;
    m_c[3] = 32'h4040_0000; m_c[4] = 32'h4080_0000; m_c[5] = 32'h0;
    m_thr = thr;
    res_val = 32'h40A0_0000;
  endtask

  function automatic logic [31:0] rand_res(input logic [31:0] thr);
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r = thr;
      1: r = {1'b0, thr[30:0] + 31'd1};
      2: r = (thr[30:0] == 31'd0) ? 32'h0 : {1'b0, thr[30:0] - 31'd1};
      3: r = {r[31], 8'hFF, r[22:0]};
      4: r = {r[31], 31'd0};
      default: r = {r[31], 8'(120 + $urandom_range(0, 15)), r[22:0]};
    endcase
    return r;
  endfunction

  initial begin
    int vcount;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_values("reset");
    RST = 1'b1;
    @(negedge CLK);

    // Basic collide: |(3,4,0)| = 5.0 < 6.0
    set_basic_pair(8'h11, 32'h40C0_0000);
    lat = 10; never = 1'b0;
    start_pair();
    check_clear(1'b0);
    wait_result();
    chk("basic_collide_const", 32'(out_collide), 32'd1);
    chk("basic_dist_const", out_dist, 32'h40A0_0000);
    release_out();

    // Equal distance and threshold is not a collision; stale ready during clear is ignored
    set_basic_pair(8'h22, 32'h40A0_0000);
    start_pair();
    check_clear(1'b1);
    wait_result();
    chk("equal_no_collide_const", 32'(out_collide), 32'd0);
    release_out();

    // Timeout, then ready landing on the very last RUN cycle, then one cycle too late
    set_basic_pair(8'h33, 32'h40C0_0000);
    never = 1'b1;
    start_pair(); check_clear(1'b0); wait_result();
    chk("timeout_flag_const", 32'(out_timeout), 32'd1);
    release_out();
    never = 1'b0;
    foreach (m_c[i]) m_c[i] = $urandom;
    lat = TMO - 1; m_tag = 8'h34;
    start_pair(); check_clear(1'b0); wait_result(); release_out();
    lat = TMO; m_tag = 8'h35;
    start_pair(); check_clear(1'b0); wait_result(); release_out();

    // Threshold of zero never collides, even against -0
    set_basic_pair(8'h36, 32'h0);
    res_val = 32'h8000_0000; lat = 3;
    start_pair(); check_clear(1'b0); wait_result(); release_out();

    // Backpressure with a second pair waiting on in_valid
    set_basic_pair(8'h44, 32'h40C0_0000);
    lat = 5;
    start_pair(); check_clear(1'b0); wait_result();
    m_tag = 8'h45;
    foreach (m_c[i]) m_c[i] = $urandom;
    m_thr = 32'h4100_0000;
    drive_pair();
    hold_check(50);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    chk("b2b_in_ready_after_hs", 32'(in_ready), 32'd1);
    res_val = 32'h40E0_0000; lat = 7;
    start_pair();
    chk("b2b_accept_cycle", 32'(t_acc), 32'(cyc));
    check_clear(1'b0); wait_result(); release_out();

    // Reset in the fifth RUN cycle drops the pair
    set_basic_pair(8'h55, 32'h40C0_0000);
    lat = 15;
    start_pair(); check_clear(1'b0);
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    check_reset_values("midrun_reset");
    vcount = 0;
    repeat (40) begin
      @(negedge CLK);
      if (out_valid === 1'b1) vcount++;
    end
    chk("midrun_no_output", 32'(vcount), 32'd0);
    set_basic_pair(8'h56, 32'h40C0_0000);
    lat = 10;
    start_pair(); check_clear(1'b0); wait_result(); release_out();

    // Randomized pairs against the float reference model
    for (int n = 0; n < 16; n++) begin
      m_tag = TW'($urandom);
      foreach (m_c[i]) m_c[i] = $urandom;
      m_thr = ($urandom_range(0, 7) == 0) ? 32'h0 :
              {1'b0, 8'(120 + $urandom_range(0, 15)), 23'($urandom)};
      res_val = rand_res(m_thr);
      lat = $urandom_range(1, TMO + 3);
      never = ($urandom_range(0, 9) == 0);
      start_pair();
      check_clear(1'($urandom_range(0, 1)));
      wait_result();
      hold_check($urandom_range(0, 3));
      release_out();
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
    never = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
